ram_initiator: RTL and testbench
================================

Name: ram_initiator

Overview:
Bus-master for the single-port RAM; the initiator end of the ram_cs/ram_we/ram_addr/ram_data_io protocol that the RAM block responds to.
Accepts read/write commands on a valid/ready request channel and buffers them in a small command FIFO.
Sequences each command onto the RAM pins, owns the tristate on the shared data bus, and returns read data on a valid/ready response channel.
Sits between a system-side client (DMA, CPU bridge) and the ram block.

Parameters:
ADDR_WIDTH, 8, RAM address width
DATA_WIDTH, 8, RAM data width
READ_LATENCY, 1, edges after the RAM samples a read command until ram_data_io is sampled by this block; legal range >=1
FIFO_DEPTH, 4, command FIFO entries; power of two, >=2

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
req_valid_i  in  1  command valid
req_ready_o  out  1  command accepted when valid&ready
req_we_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_WIDTH  command address
req_wdata_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  read data valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  DATA_WIDTH  read data
ram_cs_o  out  1  RAM chip select
ram_we_o  out  1  RAM write enable
ram_addr_o  out  ADDR_WIDTH  RAM address
ram_data_io  inout  DATA_WIDTH  shared data; driven only while the internal oe is 1, else 'z
busy_o  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset: synchronous on rst_i=1.
  - Reset values: FIFO empty; FSM=IDLE; ram_cs_o=0, ram_we_o=0, ram_addr_o=0; oe=0 (bus 'z); rsp_valid_o=0, rsp_rdata_o=0; busy_o=0.
  - req_ready_o=0 while rst_i=1.
  - Reset mid-operation drops all buffered and in-flight commands; no response is issued for them.
- FIFO:
  - req_ready_o = !full, computed from the registered count.
  - A pop while full does not admit a same-cycle push.
  - Simultaneous push+pop when not full keeps the count unchanged.
- All RAM pins are registered; a pop at edge E drives the pins during cycle E..E+1, and the RAM samples them at E+1.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RESP, TURN.
- IDLE:
  - FIFO non-empty: pop the head.
  - Write head: cs=1, we=1, oe=1, addr and data loaded; go to WR.
  - Read head: cs=1, we=0, oe=0, addr loaded; go to RD_ISSUE.
- WR (pins hold the write for one cycle):
  - If the FIFO is non-empty, pop the next head directly; a write stays in WR, a read goes to RD_ISSUE. Back-to-back writes run at one per cycle.
  - Otherwise cs=0, we=0, oe=0; go to IDLE.
- RD_ISSUE: cs=0, we=0, oe=0; load the wait counter with READ_LATENCY-1; go to RD_WAIT.
- RD_WAIT: when the counter is 0, sample ram_data_io into rsp_rdata_o, set rsp_valid_o=1, go to RESP; else decrement.
- RESP: hold rsp_valid_o and rsp_rdata_o stable until rsp_ready_i=1; on handshake clear rsp_valid_o and go to TURN.
- TURN: one bus-turnaround cycle with all pins idle and oe=0; go to IDLE.
  - Guarantees at least one undriven cycle between the RAM driving read data and this block driving a write.
- Read timing:
  - Request accepted at edge E0, popped at E1.
  - rsp_valid_o rises at edge E0+READ_LATENCY+2, i.e. 3 edges after acceptance at the default latency.
  - Write accepted at E0 is committed in the RAM at E0+2.
- No command is popped in RD_ISSUE, RD_WAIT, RESP or TURN; reads are strictly serialised and responses stay in order.
- oe is never 1 while the FSM is in RD_ISSUE, RD_WAIT, RESP or TURN (assertion).
- Address and data are passed through unmodified; no wrap or arithmetic.

Decomposition:
- Package ram_initiator_pkg:
  - state enum (6 states);
  - cmd struct {we, addr, wdata} parameterised through localparams;
  - localparam for the wait-counter width, $clog2(READ_LATENCY+1).
- Sub-module ram_cmd_fifo:
  - synchronous FIFO of cmd structs, FIFO_DEPTH entries;
  - ports push/pop/full/empty/head;
  - same clock and synchronous active-high reset.

Test Plan:
- Write addr 0x10 data 0xA5, then read 0x10, rsp_ready_i=1 -> rsp_valid_o rises 3 edges after read acceptance with rsp_rdata_o=0xA5; one TURN cycle with bus 'z follows.
- 4 writes presented on consecutive cycles (addr 0..3, data 0x11..0x44) -> ram_cs_o=ram_we_o=1 for 4 consecutive cycles; reads of 0..3 return 0x11..0x44 in order.
- Hold rsp_ready_i=0 during a read, then push 6 writes -> req_ready_o drops after 4 pushes; rsp_valid_o and rsp_rdata_o stay stable; releasing rsp_ready_i drains the FIFO in order.
- Read 0x20 immediately followed by write 0x20=0x5A -> oe stays 0 from read issue through TURN; write cs is asserted only after TURN; a later read returns 0x5A.
- Assert rst_i in RD_WAIT with 2 commands queued -> next cycle all outputs are at reset values; no response is issued; the queued commands never reach the RAM.
- READ_LATENCY=3 build, write 0x7F=0xC3 then read 0x7F -> rsp_valid_o rises 5 edges after read acceptance with data 0xC3.

Source files
------------

// File: rtl/ram_initiator_pkg.sv
// Shared types for the RAM bus-master: FSM state encoding, default command
// layout and the wait-counter sizing helper.
package ram_initiator_pkg;

  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_READ_LATENCY = 1;
  localparam int DEF_FIFO_DEPTH   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RESP,
    ST_TURN
  } state_e;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } cmd_t;

  // Counter must hold READ_LATENCY-1; never narrower than one bit.
  function automatic int cnt_width(input int read_latency);
    return (read_latency < 1) ? 1 : $clog2(read_latency + 1);
  endfunction

endpackage

// File: rtl/ram_cmd_fifo.sv
// Synchronous command FIFO; power-of-two depth so the pointers wrap naturally.
// Push while full and pop while empty are ignored.
module ram_cmd_fifo
  import ram_initiator_pkg::*;
#(
  parameter type T     = cmd_t,
  parameter int  DEPTH = DEF_FIFO_DEPTH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ram_initiator.sv
// Bus-master for the single-port RAM: buffers commands, sequences them onto
// registered RAM pins, owns the shared data bus and returns read data in order.
module ram_initiator
  import ram_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  ram_cs_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  inout  wire  [DATA_WIDTH-1:0] ram_data_io,
  output logic                  busy_o
);

  localparam int CNT_WIDTH = cnt_width(READ_LATENCY);
  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(READ_LATENCY - 1);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_cmd_t;

  req_cmd_t push_cmd, head;
  logic     push, pop, fifo_full, fifo_empty;

  state_e                state_q, state_d;
  logic                  cs_q, cs_d, we_q, we_d, oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  assign push_cmd    = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i};
  assign req_ready_o = !fifo_full && !rst_i;
  assign push        = req_valid_i && req_ready_o;

  ram_cmd_fifo #(
    .T     (req_cmd_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_cmd),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    // NOTE: every *_d starts from its *_q so no path leaves a latch behind.
    state_d     = state_q;
    cs_d        = cs_q;
    we_d        = we_q;
    oe_d        = oe_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
    case (state_q)
      // WR shares IDLE's dispatch so consecutive writes issue one per cycle.
      ST_IDLE, ST_WR: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cs_d    = 1'b1;
          we_d    = head.we;
          oe_d    = head.we;
          addr_d  = head.addr;
          if (head.we) wdata_d = head.wdata;
          state_d = head.we ? ST_WR : ST_RD_ISSUE;
        end else begin
          cs_d    = 1'b0;
          we_d    = 1'b0;
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RD_ISSUE: begin
        cs_d    = 1'b0;
        we_d    = 1'b0;
        oe_d    = 1'b0;
        cnt_d   = WAIT_LOAD;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          rsp_rdata_d = ram_data_io;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_TURN;
        end
      end
      // Guarantees an undriven cycle after the RAM releases the bus.
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ram_cs_o    = cs_q;
  assign ram_we_o    = we_q;
  assign ram_addr_o  = addr_q;
  assign ram_data_io = oe_q ? wdata_q : 'z;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign busy_o      = !fifo_empty || (state_q != ST_IDLE);

  a_no_drive_during_read: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q inside {ST_RD_ISSUE, ST_RD_WAIT, ST_RESP, ST_TURN}) |-> !oe_q);

endmodule

// File: tb/tb_ram_initiator.sv
// Self-checking bench for ram_initiator: behavioural RAMs on the pin side and
// an in-order memory model predicting every read response.
module tb_ram_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // ---------------- DUT with READ_LATENCY = 1 ----------------
  logic       req_valid = 1'b0, req_we = 1'b0, req_ready;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic       ram_cs, ram_we, busy;
  logic [7:0] ram_addr;
  wire  [7:0] ram_data;

  ram_initiator #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_data_io(ram_data), .busy_o(busy)
  );

  logic [7:0] ram_mem [256];
  logic       rd_v;
  logic [7:0] rd_d;
  logic [7:0] ram_wr_log [$];
  always @(posedge clk) begin
    rd_v <= ram_cs && !ram_we;
    rd_d <= ram_mem[ram_addr];
    if (ram_cs && ram_we) begin
      ram_mem[ram_addr] <= ram_data;
      ram_wr_log.push_back(ram_addr);
    end
  end
  assign ram_data = rd_v ? rd_d : 8'bz;

  // ---------------- DUT with READ_LATENCY = 3 ----------------
  logic       req_valid_3 = 1'b0, req_we_3 = 1'b0, req_ready_3;
  logic [7:0] req_addr_3 = '0, req_wdata_3 = '0;
  logic       rsp_valid_3, rsp_ready_3 = 1'b1;
  logic [7:0] rsp_rdata_3;
  logic       ram_cs_3, ram_we_3, busy_3;
  logic [7:0] ram_addr_3;
  wire  [7:0] ram_data_3;

  ram_initiator #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(3), .FIFO_DEPTH(4)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_3), .req_ready_o(req_ready_3), .req_we_i(req_we_3),
    .req_addr_i(req_addr_3), .req_wdata_i(req_wdata_3),
    .rsp_valid_o(rsp_valid_3), .rsp_ready_i(rsp_ready_3), .rsp_rdata_o(rsp_rdata_3),
    .ram_cs_o(ram_cs_3), .ram_we_o(ram_we_3), .ram_addr_o(ram_addr_3),
    .ram_data_io(ram_data_3), .busy_o(busy_3)
  );

  logic [7:0] ram_mem3 [256];
  logic [2:0] pv3;
  logic [7:0] pd3 [3];
  always @(posedge clk) begin
    pv3    <= {pv3[1:0], ram_cs_3 && !ram_we_3};
    pd3[2] <= pd3[1];
    pd3[1] <= pd3[0];
    pd3[0] <= ram_mem3[ram_addr_3];
    if (ram_cs_3 && ram_we_3) ram_mem3[ram_addr_3] <= ram_data_3;
  end
  assign ram_data_3 = pv3[2] ? pd3[2] : 8'bz;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i]  <= 8'(i);
      ram_mem3[i] <= 8'(i);
    end
    rd_v <= 1'b0;
    pv3  <= '0;
  end

  // ---------------- reference model and pin monitor ----------------
  logic [7:0] ref_mem [256];
  logic [7:0] exp_q [$];
  int rsp_count = 0, wr_run = 0, max_wr_run = 0, cs_cycles = 0;

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      rsp_count++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got %h, required no response", rsp_rdata);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rsp_rdata !== e) begin
          errors++;
          $display("FAIL rsp_data: got %h, required %h", rsp_rdata, e);
        end
      end
    end
    if (ram_cs && ram_we) wr_run++;
    else wr_run = 0;
    if (wr_run > max_wr_run) max_wr_run = wr_run;
    if (ram_cs) cs_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input bit track, output int acc);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 100) begin tick(); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout addr %h: ready %b, required 1", addr, req_ready);
      acc = -1;
    end else begin
      tick();
      acc = edge_cnt;
      if (track) begin
        if (we) ref_mem[addr] = wdata;
        else    exp_q.push_back(ref_mem[addr]);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic push3(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                       output int acc);
    int n = 0;
    req_valid_3 = 1'b1; req_we_3 = we; req_addr_3 = addr; req_wdata_3 = wdata;
    while (!req_ready_3 && n < 100) begin tick(); n++; end
    if (!req_ready_3) begin
      checks++; errors++;
      $display("FAIL push3_timeout addr %h: ready %b, required 1", addr, req_ready_3);
      acc = -1;
    end else begin
      tick();
      acc = edge_cnt;
    end
    req_valid_3 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || rsp_valid) && n < 500) begin tick(); n++; end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_drain: pending %0d busy %b, required 0 0", name, exp_q.size(), busy);
    end
  endtask

  task automatic poll_rsp(output int rise);
    rise = -1;
    for (int i = 0; i < 30 && rise < 0; i++) begin
      if (rsp_valid) rise = edge_cnt;
      else tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [19:0] obs;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (req_ready !== 1'b0 || req_ready_3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b, required 0/0", req_ready, req_ready_3);
    end
    obs = {ram_cs, ram_we, ram_addr, dut.oe_q, rsp_valid, rsp_rdata, busy};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", obs);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready %b busy %b, required 1 0", req_ready, busy);
    end
  endtask

  task automatic test_write_read();
    int aw, ar, rise;
    logic [7:0] old;
    rsp_ready = 1'b1;
    old = ref_mem[8'h10];
    push_cmd(1'b1, 8'h10, 8'hA5, 1'b1, aw);
    push_cmd(1'b0, 8'h10, 8'h00, 1'b1, ar);
    checks++;
    if (ram_mem[8'h10] !== old) begin
      errors++;
      $display("FAIL wr_early: mem %h one edge after accept+1, required %h", ram_mem[8'h10], old);
    end
    tick();
    checks++;
    if (ram_mem[8'h10] !== 8'hA5 || edge_cnt != aw + 2) begin
      errors++;
      $display("FAIL wr_commit: mem %h at +%0d, required A5 at +2", ram_mem[8'h10], edge_cnt - aw);
    end
    poll_rsp(rise);
    checks++;
    if (rise - ar != 3) begin
      errors++;
      $display("FAIL rd_latency: got %0d edges, required 3", rise - ar);
    end
    checks++;
    if (rsp_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rd_data: got %h, required A5", rsp_rdata);
    end
    tick();
    checks++;
    if ({rsp_valid, ram_cs, dut.oe_q, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL turn_cycle: valid/cs/oe/busy %b, required 0001", {rsp_valid, ram_cs, dut.oe_q, busy});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL turn_end: busy %b, required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int acc [4];
    int r, base;
    base = rsp_count;
    wr_run = 0; max_wr_run = 0;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 8'(i), 8'(8'h11 * (i + 1)), 1'b1, acc[i]);
    checks++;
    if (acc[3] - acc[0] != 3) begin
      errors++;
      $display("FAIL b2b_accept: span %0d edges, required 3", acc[3] - acc[0]);
    end
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 8'(i), 8'h00, 1'b1, r);
    wait_idle("b2b");
    checks++;
    if (max_wr_run != 4) begin
      errors++;
      $display("FAIL b2b_write_run: got %0d cycles, required 4", max_wr_run);
    end
    checks++;
    if (rsp_count - base != 4) begin
      errors++;
      $display("FAIL b2b_rsp_count: got %0d, required 4", rsp_count - base);
    end
  endtask

  task automatic test_backpressure();
    int a, rise;
    bit stable = 1'b1;
    logic [7:0] held;
    logic [7:0] wd [6];
    rsp_ready = 1'b0;
    ram_wr_log.delete();
    push_cmd(1'b0, 8'h50, 8'h00, 1'b1, a);
    poll_rsp(rise);
    held = rsp_rdata;
    checks++;
    if (rise < 0 || held !== exp_q[0]) begin
      errors++;
      $display("FAIL bp_first_rsp: got %h valid_edge %0d, required %h", held, rise, exp_q[0]);
    end
    for (int i = 0; i < 6; i++) wd[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 8'(8'h60 + i), wd[i], 1'b1, a);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: ready %b after 4 pushes, required 0", req_ready);
    end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h64; req_wdata = wd[4];
    repeat (6) begin
      tick();
      if (!rsp_valid || rsp_rdata !== held || req_ready) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold: valid %b data %h ready %b, required 1 %h 0", rsp_valid, rsp_rdata, req_ready, held);
    end
    rsp_ready = 1'b1;
    push_cmd(1'b1, 8'h64, wd[4], 1'b1, a);
    push_cmd(1'b1, 8'h65, wd[5], 1'b1, a);
    for (int i = 0; i < 6; i++) push_cmd(1'b0, 8'(8'h60 + i), 8'h00, 1'b1, a);
    wait_idle("bp");
    checks++;
    begin
      bit ok = (ram_wr_log.size() == 6);
      for (int i = 0; i < ram_wr_log.size() && i < 6; i++)
        if (ram_wr_log[i] !== 8'(8'h60 + i)) ok = 1'b0;
      if (!ok) begin
        errors++;
        $display("FAIL bp_drain_order: %0d writes, first %h, required 6 starting 60", ram_wr_log.size(),
                 ram_wr_log.size() > 0 ? ram_wr_log[0] : 8'h00);
      end
    end
  endtask

  task automatic test_read_then_write();
    int a0, a1, first_wr = -1, r;
    bit oe_bad = 1'b0;
    rsp_ready = 1'b1;
    push_cmd(1'b0, 8'h20, 8'h00, 1'b1, a0);
    push_cmd(1'b1, 8'h20, 8'h5A, 1'b1, a1);
    for (int i = 0; i < 30 && first_wr < 0; i++) begin
      if (ram_cs && ram_we) first_wr = edge_cnt;
      else begin
        if (dut.oe_q) oe_bad = 1'b1;
        tick();
      end
    end
    checks++;
    if (oe_bad) begin
      errors++;
      $display("FAIL rtw_oe: oe seen 1 before write issue, required 0");
    end
    checks++;
    if (first_wr - a0 != 6) begin
      errors++;
      $display("FAIL rtw_write_edge: write cs at +%0d, required +6", first_wr - a0);
    end
    push_cmd(1'b0, 8'h20, 8'h00, 1'b1, r);
    wait_idle("rtw");
  endtask

  task automatic test_reset_mid();
    int a0, a1, a2, cs_before, rsp_before;
    bit saw_valid = 1'b0;
    logic [19:0] obs;
    rsp_ready = 1'b1;
    ram_wr_log.delete();
    push_cmd(1'b0, 8'h30, 8'h00, 1'b0, a0);
    push_cmd(1'b1, 8'h31, 8'hEE, 1'b0, a1);
    push_cmd(1'b1, 8'h32, 8'hDD, 1'b0, a2);
    rst = 1'b1;
    tick();
    obs = {ram_cs, ram_we, ram_addr, dut.oe_q, rsp_valid, rsp_rdata, busy};
    checks++;
    if (obs !== '0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h ready %b, required 0 0", obs, req_ready);
    end
    rst = 1'b0;
    cs_before = cs_cycles;
    rsp_before = rsp_count;
    repeat (15) begin
      tick();
      if (rsp_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid || rsp_count != rsp_before) begin
      errors++;
      $display("FAIL midrst_rsp: saw valid %b, required 0", saw_valid);
    end
    checks++;
    if (cs_cycles != cs_before || ram_wr_log.size() != 0) begin
      errors++;
      $display("FAIL midrst_ram: cs cycles %0d writes %0d, required 0 0",
               cs_cycles - cs_before, ram_wr_log.size());
    end
    checks++;
    if (ram_mem[8'h31] !== ref_mem[8'h31] || ram_mem[8'h32] !== ref_mem[8'h32]) begin
      errors++;
      $display("FAIL midrst_mem: %h %h, required %h %h", ram_mem[8'h31], ram_mem[8'h32],
               ref_mem[8'h31], ref_mem[8'h32]);
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    fork
      begin
        int a;
        for (int i = 0; i < 40; i++) begin
          push_cmd(1'($urandom_range(0, 1)), 8'(8'h80 + $urandom_range(0, 7)), 8'($urandom), 1'b1, a);
          repeat ($urandom_range(0, 2)) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rsp_ready = 1'($urandom_range(0, 1));
          tick();
        end
        rsp_ready = 1'b1;
      end
    join
    wait_idle("random");
  endtask

  task automatic test_latency3();
    int aw, ar, rise = -1;
    rsp_ready_3 = 1'b1;
    push3(1'b1, 8'h7F, 8'hC3, aw);
    push3(1'b0, 8'h7F, 8'h00, ar);
    for (int i = 0; i < 30 && rise < 0; i++) begin
      if (rsp_valid_3) rise = edge_cnt;
      else tick();
    end
    checks++;
    if (rise - ar != 5) begin
      errors++;
      $display("FAIL lat3_latency: got %0d edges, required 5", rise - ar);
    end
    checks++;
    if (rsp_rdata_3 !== 8'hC3) begin
      errors++;
      $display("FAIL lat3_data: got %h, required C3", rsp_rdata_3);
    end
    repeat (4) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_read_then_write();
    test_reset_mid();
    test_random();
    test_latency3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

endmodule
